// File: rtl/seq_control.sv
`default_nettype none
// ============================================================================
//  Module      : seq_control
//  Description : Multi-cycle Fetch/Read/Execute instruction sequencer with
//                opcode decode, program-memory handshake, selectable wait
//                switch, bounded wait with sticky timeout, conditional jump
//                on accumulator zero, and HALT with restart.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_control #(
  parameter int NSW     = 8,
  parameter int TMO_MAX = 0
) (
  input  logic                    Clock,
  input  logic                    nReset,
  input  logic [3:0]              OpCode,
  input  logic [$clog2(NSW)-1:0]  SwSel,
  input  logic [NSW-1:0]          Sw,
  input  logic                    AccZero,
  input  logic                    IMemRdy,
  input  logic                    Run,
  input  logic                    ClrTmo,
  output logic                    IMemReq,
  output logic                    RegWe,
  output logic                    WDataSel,
  output logic                    AccStore,
  output logic                    Op1Sel,
  output logic                    ImmSel,
  output logic [1:0]              AluOp,
  output logic [1:0]              PcSel,
  output logic                    TmoFlag,
  output logic                    Halted
);

  // Counter must hold TMO_MAX; keep at least one bit when the timeout is off.
  localparam int CW = (TMO_MAX > 0) ? $clog2(TMO_MAX + 1) : 1;
  localparam logic [CW-1:0] c_TMO_CNT = CW'(TMO_MAX);

  localparam logic [3:0] c_OP_NOOP  = 4'b0000;
  localparam logic [3:0] c_OP_WAIT0 = 4'b0001;
  localparam logic [3:0] c_OP_WAIT1 = 4'b0010;
  localparam logic [3:0] c_OP_STSW  = 4'b0011;
  localparam logic [3:0] c_OP_STACC = 4'b0100;
  localparam logic [3:0] c_OP_JMPA  = 4'b0101;
  localparam logic [3:0] c_OP_JMPZ  = 4'b0110;
  localparam logic [3:0] c_OP_HALT  = 4'b0111;
  localparam logic [3:0] c_OP_PASSA = 4'b1000;
  localparam logic [3:0] c_OP_ADD   = 4'b1001;
  localparam logic [3:0] c_OP_MULT  = 4'b1010;
  localparam logic [3:0] c_OP_LUI   = 4'b1100;
  localparam logic [3:0] c_OP_ADDI  = 4'b1101;

  localparam logic [1:0] c_PC_WAIT = 2'b00;
  localparam logic [1:0] c_PC_INC  = 2'b01;
  localparam logic [1:0] c_PC_JMP  = 2'b10;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    READ  = 2'b01,
    EXEC  = 2'b10,
    HALT  = 2'b11
  } state_t;

  state_t        rState;
  logic [CW-1:0] rWaitCnt;
  logic          rTmoFlag;

  logic wSwBit;
  logic wInExec;
  logic wUnsat;
  logic wTimeout;

  // Selected wait switch; out-of-range indices read as 0.
  always_comb begin
    wSwBit = 1'b0;
    if (int'(SwSel) < NSW) begin
      wSwBit = Sw[SwSel];
    end
  end

  assign wInExec  = (rState == EXEC);
  assign wUnsat   = ((OpCode == c_OP_WAIT0) && !wSwBit) ||
                    ((OpCode == c_OP_WAIT1) &&  wSwBit);
  // Timeout fires on the EXEC where the counter has already reached the limit.
  assign wTimeout = (TMO_MAX > 0) && wInExec && wUnsat && (rWaitCnt == c_TMO_CNT);

  // Sequencer state, wait-retry counter and sticky timeout flag.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      rState   <= FETCH;
      rWaitCnt <= '0;
      rTmoFlag <= 1'b0;
    end else begin
      case (rState)
        FETCH:   if (IMemRdy) rState <= READ;
        READ:    rState <= EXEC;
        EXEC:    rState <= (OpCode == c_OP_HALT) ? HALT : FETCH;
        HALT:    if (Run) rState <= FETCH;
        default: rState <= FETCH;
      endcase

      if (wInExec) begin
        if (wTimeout) begin
          rWaitCnt <= '0;
        end else if (wUnsat) begin
          // Saturate rather than wrap when the timeout is disabled.
          if (rWaitCnt != {CW{1'b1}}) rWaitCnt <= rWaitCnt + CW'(1);
        end else begin
          rWaitCnt <= '0;
        end
      end

      // A timeout on the same edge as ClrTmo keeps the flag set.
      if (wTimeout) begin
        rTmoFlag <= 1'b1;
      end else if (ClrTmo) begin
        rTmoFlag <= 1'b0;
      end
    end
  end

  // Opcode decode; strobes only ever assert during EXEC.
  always_comb begin
    RegWe    = 1'b0;
    WDataSel = 1'b0;
    AccStore = 1'b0;
    Op1Sel   = 1'b0;
    ImmSel   = 1'b0;
    PcSel    = c_PC_WAIT;
    if (wInExec) begin
      PcSel = c_PC_INC;
      case (OpCode)
        c_OP_NOOP: ;
        c_OP_WAIT0,
        c_OP_WAIT1: if (wUnsat && !wTimeout) PcSel = c_PC_WAIT;
        c_OP_STSW: begin
          RegWe    = 1'b1;
          WDataSel = 1'b1;
        end
        c_OP_STACC: RegWe = 1'b1;
        c_OP_JMPA: begin
          Op1Sel = 1'b1;
          PcSel  = c_PC_JMP;
        end
        c_OP_JMPZ: begin
          Op1Sel = 1'b1;
          PcSel  = AccZero ? c_PC_JMP : c_PC_INC;
        end
        c_OP_HALT: PcSel = c_PC_WAIT;
        c_OP_PASSA,
        c_OP_ADD,
        c_OP_MULT: AccStore = 1'b1;
        c_OP_LUI: begin
          AccStore = 1'b1;
          Op1Sel   = 1'b1;
          ImmSel   = 1'b1;
        end
        c_OP_ADDI: begin
          AccStore = 1'b1;
          Op1Sel   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign AluOp   = OpCode[1:0];
  assign IMemReq = (rState == FETCH);
  assign Halted  = (rState == HALT);
  assign TmoFlag = rTmoFlag;

endmodule
`default_nettype wire

// File: tb/tb_seq_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_control
//  Description : Self-checking bench for seq_control. Two instances share
//                stimulus: one with the timeout disabled, one with TMO_MAX=2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_control;

  localparam int NSW = 8;

  logic       Clock = 1'b0;
  logic       nReset;
  logic [3:0] OpCode;
  logic [2:0] SwSel;
  logic [7:0] Sw;
  logic       AccZero, IMemRdy, Run, ClrTmo;

  logic       aReq, aRegWe, aWDataSel, aAccStore, aOp1Sel, aImmSel, aTmo, aHalted;
  logic [1:0] aAluOp, aPcSel;
  logic       bReq, bRegWe, bWDataSel, bAccStore, bOp1Sel, bImmSel, bTmo, bHalted;
  logic [1:0] bAluOp, bPcSel;

  int errors = 0;
  int checks = 0;

  always #5 Clock = ~Clock;

  seq_control #(.NSW(NSW), .TMO_MAX(0)) dutA (
    .Clock(Clock), .nReset(nReset), .OpCode(OpCode), .SwSel(SwSel), .Sw(Sw),
    .AccZero(AccZero), .IMemRdy(IMemRdy), .Run(Run), .ClrTmo(ClrTmo),
    .IMemReq(aReq), .RegWe(aRegWe), .WDataSel(aWDataSel), .AccStore(aAccStore),
    .Op1Sel(aOp1Sel), .ImmSel(aImmSel), .AluOp(aAluOp), .PcSel(aPcSel),
    .TmoFlag(aTmo), .Halted(aHalted)
  );

  seq_control #(.NSW(NSW), .TMO_MAX(2)) dutB (
    .Clock(Clock), .nReset(nReset), .OpCode(OpCode), .SwSel(SwSel), .Sw(Sw),
    .AccZero(AccZero), .IMemRdy(IMemRdy), .Run(Run), .ClrTmo(ClrTmo),
    .IMemReq(bReq), .RegWe(bRegWe), .WDataSel(bWDataSel), .AccStore(bAccStore),
    .Op1Sel(bOp1Sel), .ImmSel(bImmSel), .AluOp(bAluOp), .PcSel(bPcSel),
    .TmoFlag(bTmo), .Halted(bHalted)
  );

  // Output vector: {IMemReq, RegWe, WDataSel, AccStore, Op1Sel, ImmSel, AluOp, PcSel, Halted}
  function automatic logic [10:0] packA();
    return {aReq, aRegWe, aWDataSel, aAccStore, aOp1Sel, aImmSel, aAluOp, aPcSel, aHalted};
  endfunction

  function automatic logic [10:0] packB();
    return {bReq, bRegWe, bWDataSel, bAccStore, bOp1Sel, bImmSel, bAluOp, bPcSel, bHalted};
  endfunction

  typedef struct {
    logic [3:0] op;
    logic [2:0] swSel;
    logic [7:0] sw;
    logic       accZero;
    logic [4:0] strb;   // {RegWe, WDataSel, AccStore, Op1Sel, ImmSel}
    logic [1:0] pc;
  } vec_t;

  typedef struct {
    string       name;
    logic [10:0] expA;
    logic [10:0] expB;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[19];

  task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Both instances must show the same non-EXEC outputs.
  task automatic chkIdle(input string nm, input logic req, input logic halted);
    logic [10:0] exp;
    exp = {req, 5'b00000, OpCode[1:0], 2'b00, halted};
    chk({nm, "/A"}, packA(), exp);
    chk({nm, "/B"}, packB(), exp);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Issue one instruction from FETCH; expected EXEC outputs go through the scoreboard.
  task automatic runInstr(input string nm, input logic [3:0] op, input logic [2:0] swSel,
                          input logic [7:0] sw, input logic accZero, input int stall,
                          input logic [4:0] strb, input logic [1:0] pcA, input logic [1:0] pcB);
    exp_t e;
    OpCode  = op;
    SwSel   = swSel;
    Sw      = sw;
    AccZero = accZero;
    e.name  = nm;
    e.expA  = {1'b0, strb, op[1:0], pcA, 1'b0};
    e.expB  = {1'b0, strb, op[1:0], pcB, 1'b0};
    sbq.push_back(e);
    IMemRdy = 1'b0;
    for (int i = 0; i < stall; i++) begin
      #1 chkIdle({nm, "-stall"}, 1'b1, 1'b0);
      step();
    end
    IMemRdy = 1'b1;
    #1 chkIdle({nm, "-fetch"}, 1'b1, 1'b0);
    step();
    IMemRdy = 1'b0;
    #1 chkIdle({nm, "-read"}, 1'b0, 1'b0);
    step();
    #1;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL %s-sb: got empty scoreboard expected one entry", nm);
    end else begin
      e = sbq.pop_front();
      chk({e.name, "-exec/A"}, packA(), e.expA);
      chk({e.name, "-exec/B"}, packB(), e.expB);
    end
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{4'h0, 3'd0, 8'h00, 1'b0, 5'b00000, 2'b01};  // NOOP
    tbl[1]  = '{4'h1, 3'd3, 8'h08, 1'b0, 5'b00000, 2'b01};  // WAIT0 satisfied
    tbl[2]  = '{4'h2, 3'd6, 8'hBF, 1'b0, 5'b00000, 2'b01};  // WAIT1 satisfied
    tbl[3]  = '{4'h3, 3'd0, 8'h00, 1'b0, 5'b11000, 2'b01};  // STSW
    tbl[4]  = '{4'h4, 3'd0, 8'h00, 1'b0, 5'b10000, 2'b01};  // STACC
    tbl[5]  = '{4'h5, 3'd0, 8'h00, 1'b0, 5'b00010, 2'b10};  // JMPA
    tbl[6]  = '{4'h6, 3'd0, 8'h00, 1'b1, 5'b00010, 2'b10};  // JMPZ taken
    tbl[7]  = '{4'h6, 3'd0, 8'h00, 1'b0, 5'b00010, 2'b01};  // JMPZ not taken
    tbl[8]  = '{4'h8, 3'd0, 8'h00, 1'b0, 5'b00100, 2'b01};  // PASSA
    tbl[9]  = '{4'h9, 3'd0, 8'h00, 1'b0, 5'b00100, 2'b01};  // ADD
    tbl[10] = '{4'hA, 3'd0, 8'h00, 1'b0, 5'b00100, 2'b01};  // MULT
    tbl[11] = '{4'hB, 3'd0, 8'h00, 1'b0, 5'b00000, 2'b01};  // reserved
    tbl[12] = '{4'hC, 3'd0, 8'h00, 1'b0, 5'b00111, 2'b01};  // LUI
    tbl[13] = '{4'hD, 3'd0, 8'h00, 1'b0, 5'b00110, 2'b01};  // ADDI
    tbl[14] = '{4'hE, 3'd0, 8'h00, 1'b0, 5'b00000, 2'b01};  // reserved
    tbl[15] = '{4'hF, 3'd0, 8'h00, 1'b0, 5'b00000, 2'b01};  // reserved
    tbl[16] = '{4'h2, 3'd2, 8'h04, 1'b0, 5'b00000, 2'b00};  // WAIT1 unsatisfied
    tbl[17] = '{4'h1, 3'd7, 8'h7F, 1'b1, 5'b00000, 2'b00};  // WAIT0 unsatisfied
    tbl[18] = '{4'h0, 3'd0, 8'h00, 1'b0, 5'b00000, 2'b01};  // NOOP clears count

    // Power-on reset
    nReset = 1'b0; OpCode = 4'h9; SwSel = '0; Sw = '0;
    AccZero = 1'b0; IMemRdy = 1'b0; Run = 1'b0; ClrTmo = 1'b0;
    #2 chkIdle("reset", 1'b1, 1'b0);
    chk("reset-tmo", {9'b0, aTmo, bTmo}, 11'b0);
    #10 nReset = 1'b1;
    step();
    chkIdle("fetch-hold", 1'b1, 1'b0);

    // Reset asserted during EXEC of STSW discards it
    OpCode = 4'h3; IMemRdy = 1'b1;
    step();
    step();
    chk("stsw-exec-pre", packA(), {1'b0, 5'b11000, 2'b11, 2'b01, 1'b0});
    nReset = 1'b0;
    #1 chkIdle("stsw-reset", 1'b1, 1'b0);
    #3 nReset = 1'b1;
    #1 chkIdle("release-c1", 1'b1, 1'b0);
    step();
    #1 chkIdle("release-c2", 1'b0, 1'b0);
    step();
    #1 chk("release-c3-exec", packA(), {1'b0, 5'b11000, 2'b11, 2'b01, 1'b0});
    step();
    IMemRdy = 1'b0;

    // Decode table
    for (int i = 0; i < 19; i++) begin
      runInstr($sformatf("tbl%0d", i), tbl[i].op, tbl[i].swSel, tbl[i].sw, tbl[i].accZero,
               0, tbl[i].strb, tbl[i].pc, tbl[i].pc);
    end

    // Fetch stall: EXEC on cycle 7
    runInstr("add-stall4", 4'h9, 3'd0, 8'h00, 1'b0, 4, 5'b00100, 2'b01, 2'b01);

    // WAIT1 on Sw[5] held high three times, then released
    for (int k = 0; k < 3; k++) begin
      runInstr($sformatf("wait1-hold%0d", k), 4'h2, 3'd5, 8'h20, 1'b0, 0, 5'b00000,
               2'b00, (k == 2) ? 2'b01 : 2'b00);
    end
    chk("wait1-tmoA", {10'b0, aTmo}, 11'd0);
    chk("wait1-tmoB", {10'b0, bTmo}, 11'd1);
    runInstr("wait1-release", 4'h2, 3'd5, 8'h00, 1'b0, 0, 5'b00000, 2'b01, 2'b01);
    chk("wait1-tmoA-end", {10'b0, aTmo}, 11'd0);

    // HALT; Run held across the entering edge is ignored
    Run = 1'b1;
    runInstr("halt", 4'h7, 3'd0, 8'h00, 1'b0, 0, 5'b00000, 2'b00, 2'b00);
    Run = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1 chkIdle($sformatf("halted%0d", c), 1'b0, 1'b1);
      step();
    end
    Run = 1'b1;
    #1 chkIdle("halt-run", 1'b0, 1'b1);
    step();
    Run = 1'b0;
    #1 chkIdle("after-run", 1'b1, 1'b0);
    runInstr("post-halt-e", 4'hE, 3'd0, 8'h00, 1'b0, 0, 5'b00000, 2'b01, 2'b01);

    // Timeout with TMO_MAX=2
    nReset = 1'b0;
    #1 chk("tmo-reset", {9'b0, aTmo, bTmo}, 11'b0);
    #2 nReset = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      runInstr($sformatf("wait0-tmo%0d", k), 4'h1, 3'd0, 8'h00, 1'b0, 0, 5'b00000,
               2'b00, (k == 2) ? 2'b01 : 2'b00);
      chk($sformatf("wait0-flagB%0d", k), {10'b0, bTmo}, (k == 2) ? 11'd1 : 11'd0);
    end
    chk("wait0-flagA", {10'b0, aTmo}, 11'd0);
    ClrTmo = 1'b1;
    step();
    ClrTmo = 1'b0;
    #1 chk("clrtmo", {10'b0, bTmo}, 11'd0);

    // Set and clear on the same edge: set wins
    for (int k = 0; k < 3; k++) begin
      if (k == 2) ClrTmo = 1'b1;
      runInstr($sformatf("wait0-clr%0d", k), 4'h1, 3'd0, 8'h00, 1'b0, 0, 5'b00000,
               2'b00, (k == 2) ? 2'b01 : 2'b00);
    end
    chk("set-wins", {10'b0, bTmo}, 11'd1);
    ClrTmo = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_control.md
# seq_control

Parametrised multi-cycle instruction sequencer for the soft processor datapath. It steps each instruction through Fetch/Read/Execute and decodes the 4-bit opcode into register-file, accumulator, ALU-operand and PC-select strobes. Compared with the fixed single-switch controller, it adds:
- a program-memory ready handshake;
- a selectable wait switch from an NSW-wide bank;
- a bounded wait with a sticky timeout flag;
- a conditional jump on accumulator zero;
- a HALT state with a restart input.

## Interface
- NSW, 8: number of switch inputs selectable for WAIT0/WAIT1; must be ≥2.
- TMO_MAX, 0: maximum consecutive unsatisfied WAIT executions before forced advance; 0 disables the timeout.
- Clock  input  1  system clock, rising edge.
- nReset  input  1  reset nReset, asynchronous, active-low.
- OpCode  input  4  current instruction opcode, stable from Read through Execute.
- SwSel  input  $clog2(NSW)  index of the switch tested by WAIT0/WAIT1; indices ≥ NSW read as 0.
- Sw  input  NSW  switch bank.
- AccZero  input  1  accumulator equals zero.
- IMemRdy  input  1  program memory has the instruction valid.
- Run  input  1  single-cycle pulse that restarts the sequencer from HALT.
- ClrTmo  input  1  clears TmoFlag.
- IMemReq  output  1  instruction fetch request.
- RegWe, WDataSel, AccStore, Op1Sel, ImmSel  output  1 each  datapath strobes.
- AluOp  output  2  ALU function: 00 pass A, 01 add, 10 mult, 11 reserved.
- PcSel  output  2  PC next-value select: 00 PcWait, 01 PcInc, 10 PcJmp.
- TmoFlag  output  1  sticky wait-timeout indicator.
- Halted  output  1  sequencer is in HALT.

## Operation
- States: FETCH, READ, EXEC, HALT. Reset state: FETCH.
- FETCH: IMemReq=1. Go to READ on the first cycle IMemRdy=1; otherwise stay.
- READ: always go to EXEC.
- EXEC: go to FETCH, except HALT opcode, which goes to HALT.
- HALT: stay until Run=1, then go to FETCH.
- Outside EXEC, every strobe is 0 and PcSel=PcWait.
- AluOp=OpCode[1:0] combinationally in all states.
- Decode in EXEC, with PcInc and all strobes 0 unless listed:
  - 0000 NOOP: defaults.
  - 0001 WAIT0: PcWait if Sw[SwSel]=0.
  - 0010 WAIT1: PcWait if Sw[SwSel]=1.
  - 0011 STSW: RegWe=1, WDataSel=1.
  - 0100 STACC: RegWe=1.
  - 0101 JMPA: Op1Sel=1, PcJmp.
  - 0110 JMPZ: Op1Sel=1; PcJmp if AccZero=1, else PcInc.
  - 0111 HALT: PcWait.
  - 1000 PASSA, 1001 ADD, 1010 MULT: AccStore=1.
  - 1100 LUI: AccStore=1, Op1Sel=1, ImmSel=1.
  - 1101 ADDI: AccStore=1, Op1Sel=1.
  - 1011, 1110, 1111: treated as NOOP; AccStore=0.
- Wait counter (width $clog2(TMO_MAX+1), minimum 1):
  - Increments at the end of each EXEC where a WAIT is unsatisfied.
  - Clears at the end of any other EXEC.
  - If TMO_MAX>0 and the counter equals TMO_MAX during an unsatisfied-WAIT EXEC: drive PcInc instead of PcWait, set TmoFlag, clear the counter.
  - Never wraps.
- TmoFlag:
  - Set as above.
  - Cleared by ClrTmo=1 on a rising edge.
  - Set wins if set and ClrTmo coincide.
- Halted=1 exactly while the state is HALT.

## Timing
- Reset (asynchronous assert) forces state FETCH, counter 0 and TmoFlag 0. Resulting outputs:
  - IMemReq=1.
  - RegWe, WDataSel, AccStore, Op1Sel, ImmSel = 0.
  - PcSel=PcWait.
  - Halted=0.
  - AluOp follows OpCode.
- Reset mid-instruction discards the instruction; no strobe is asserted on the reset-release cycle.
- Instruction latency is 3 cycles plus N, where N is the number of FETCH cycles with IMemRdy=0. Strobes are valid for exactly one cycle, the EXEC cycle; the datapath samples them on the rising edge ending EXEC.
- An unsatisfied WAIT costs 3 cycles per retry when IMemRdy=1 is held.
- Run sampled in any state other than HALT is ignored.
- Run on the same edge that enters HALT is ignored. The first usable Run is in the cycle after Halted rises.
- IMemRdy is sampled only in FETCH.
- All outputs except AluOp are functions of registered state and the current inputs. There are no combinational paths from IMemRdy or Run to strobes.

## Test plan
- Reset low mid-EXEC of STSW, then release, with IMemRdy=1 -> RegWe is not asserted. First EXEC occurs on cycle 3 after release with IMemReq=1, PcSel=PcWait before it.
- IMemRdy held 0 for 4 cycles, then ADD issued -> EXEC on cycle 7 (4 stall + 3). AccStore=1 and AluOp=01 for exactly one cycle.
- NSW=8, SwSel=5, WAIT1 with Sw[5]=1 for 3 executions, then Sw[5]=0 -> PcSel=PcWait in 3 EXEC cycles, then PcInc. TmoFlag stays 0 with TMO_MAX=0.
- TMO_MAX=2, WAIT0 with Sw all 0 -> PcWait in EXECs 1 and 2; EXEC 3 gives PcInc and TmoFlag=1. ClrTmo pulse clears it. Set and clear on the same edge leaves it 1.
- JMPZ with AccZero=1 -> PcJmp, Op1Sel=1. With AccZero=0 -> PcInc, Op1Sel=1.
- HALT -> Halted=1 from the next cycle, all strobes 0. Run held 10 cycles later -> FETCH on the next cycle, Halted=0. Reserved opcode 1110 -> no strobes, PcInc.
